fixed_point_adder_pipe: RTL and testbench
=========================================

// Module: fixed_point_adder_pipe
// PURPOSE
//  Parametrised successor to the 8-bit fixed-point adder. Signed two's-complement Q-format
//  add/sub/accumulate unit: 2-stage pipeline, valid/ready on both sides,
//  saturate-or-wrap overflow handling, sticky overflow flag. Sits between sample
//  sources and the FIR/IIR datapaths.
// PARAMETERS
//  DATA_W    8  operand/result width in bits, >= 4
//  FRAC_W    4  fractional bits (Q-format label); no effect on logic, < DATA_W
//  SATURATE  1  1: clamp on overflow; 0: two's-complement wrap
// PORTS
//  i_clk          in   1       clock, all logic on rising edge
//  i_reset_n      in   1       synchronous, active-low reset
//  i_valid        in   1       input transaction valid
//  o_ready        out  1       unit accepts input this cycle
//  i_a            in   DATA_W  operand A (signed)
//  i_b            in   DATA_W  operand B (signed)
//  i_mode         in   2       00 A+B, 01 A-B, 10 ACC+A, 11 load ACC<=A
//  o_valid        out  1       result valid
//  i_ready        in   1       downstream accepts result
//  o_data         out  DATA_W  result (signed)
//  o_overflow     out  1       overflow occurred on this o_data, qualified by o_valid
//  o_ovf_sticky   out  1       set by any overflow, cleared by i_clr_sticky
//  i_clr_sticky   in   1       clear sticky flag
// BEHAVIOUR
//  - Reset (i_reset_n=0 at edge): s1_valid, o_valid, o_data, o_overflow,
//    o_ovf_sticky, ACC all 0. In-flight transactions are discarded.
//  - Stage 1: registers i_a, i_b, i_mode, and s1_valid on input handshake.
//  - Stage 2: computes result and loads o_data, o_overflow, o_valid. Latency is 2 cycles
//    from input handshake to o_valid when i_ready stays high.
//  - adv2 = !o_valid | i_ready; adv1 = !s1_valid | adv2; o_ready = adv1.
//    The combinational i_ready->o_ready path is intentional and bubble-free:
//    full throughput is 1 transaction per cycle.
//  - o_valid=1 and i_ready=0: o_data and o_overflow hold stable, and the pipeline stalls.
//    No transaction is dropped or duplicated, and order is preserved.
//  - Arithmetic: sign-extend to DATA_W+1. Overflow when bit DATA_W != bit DATA_W-1.
//    - SATURATE=1: positive overflow -> 2^(DATA_W-1)-1, negative overflow -> -2^(DATA_W-1).
//    - SATURATE=0: low DATA_W bits.
//  - Mode 11: result = A, overflow = 0.
//  - ACC is updated in stage 2 on the same edge as o_data, only for modes 10/11.
//    ACC takes the post-saturation/wrap result.
//  - Back-to-back ACC ops therefore see the previous result, with no hazard.
//  - Sticky flag:
//    - Set on any stage-2 load with overflow.
//    - Set has priority over i_clr_sticky in the same cycle.
//    - i_clr_sticky alone clears it on the next edge.
//  - i_valid with o_ready=0: no capture; the source must hold its data.
// STRUCTURE
//  - Package fixed_point_pkg:
//    - mode localparams MODE_ADD/MODE_SUB/MODE_ACC/MODE_LOAD
//    - functions sat_max(w)/sat_min(w)
//  - Sub-module fxp_add_sat: combinational (a, b, sub, saturate) -> (sum, ovf).
//    The FSM-free pipeline and handshake stay in the top.
// TESTING (DATA_W=8, FRAC_W=4)
//  1. ADD 0x18+0x28 (1.5+2.5) -> 2 cycles later o_data=0x40, o_overflow=0.
//  2. SAT=1: ADD 0x70+0x20 -> 0x7F, ovf=1, sticky=1.
//     SUB 0x80-0x01 -> 0x80, ovf=1.
//     SAT=0: 0x70+0x20 -> 0x90, ovf=1.
//  3. LOAD 0x10, then ACC+0x10 x3 back-to-back -> 0x10, 0x20, 0x30, 0x40 on
//     consecutive cycles; ACC=0x40.
//  4. Stream of 6 ADDs, i_ready low for 3 cycles mid-stream -> o_ready low
//     while full, o_data held, all 6 results in order, no gaps once ready returns.
//  5. Overflow and i_clr_sticky in same cycle -> sticky stays 1;
//     clr next cycle -> 0.
//  6. Reset asserted with 2 in flight -> next cycle o_valid=0, ACC=0, sticky=0;
//     ACC+0x05 after release -> 0x05.
//  - Formal: miter of reference vs mutant (mutsel) on o_data/o_valid under equal inputs.

Source files
------------

// File: rtl/fixed_point_adder_pipe_pkg.sv
// Shared definitions for the fixed-point add/sub/accumulate pipeline.
package fixed_point_pkg;

  localparam logic [1:0] MODE_ADD  = 2'b00;  // A + B
  localparam logic [1:0] MODE_SUB  = 2'b01;  // A - B
  localparam logic [1:0] MODE_ACC  = 2'b10;  // ACC + A
  localparam logic [1:0] MODE_LOAD = 2'b11;  // ACC <= A

  // Largest positive two's-complement value representable in w bits.
  function automatic int sat_max(input int w);
    return (1 << (w - 1)) - 1;
  endfunction

  // Most negative two's-complement value representable in w bits.
  function automatic int sat_min(input int w);
    return -(1 << (w - 1));
  endfunction

endpackage

// File: rtl/fixed_point_adder_pipe_if.sv
// Input/output handshake bundle of the fixed-point adder pipeline.
interface fixed_point_adder_pipe_if #(
  parameter int DATA_W = 8
);
  logic              i_valid;
  logic              o_ready;
  logic [DATA_W-1:0] i_a;
  logic [DATA_W-1:0] i_b;
  logic [1:0]        i_mode;
  logic              o_valid;
  logic              i_ready;
  logic [DATA_W-1:0] o_data;
  logic              o_overflow;
  logic              o_ovf_sticky;
  logic              i_clr_sticky;

  // Unit side.
  modport slave (
    input  i_valid, i_a, i_b, i_mode, i_ready, i_clr_sticky,
    output o_ready, o_valid, o_data, o_overflow, o_ovf_sticky
  );

  // Source/sink side.
  modport master (
    output i_valid, i_a, i_b, i_mode, i_ready, i_clr_sticky,
    input  o_ready, o_valid, o_data, o_overflow, o_ovf_sticky
  );
endinterface

// File: rtl/fixed_point_adder_pipe_add_sat.sv
// Combinational signed add/subtract with overflow detect and optional clamp.
module fxp_add_sat
  import fixed_point_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              sub,
  input  logic              saturate,
  output logic [DATA_W-1:0] sum,
  output logic              ovf
);

  localparam logic [DATA_W-1:0] MAX_V = DATA_W'(sat_max(DATA_W));
  localparam logic [DATA_W-1:0] MIN_V = DATA_W'(sat_min(DATA_W));

  logic [DATA_W:0] ext_a;
  logic [DATA_W:0] ext_b;
  logic [DATA_W:0] raw;

  // One guard bit catches overflow; its sign picks the clamp direction.
  always_comb begin
    ext_a = {a[DATA_W-1], a};
    ext_b = {b[DATA_W-1], b};
    raw   = sub ? (ext_a - ext_b) : (ext_a + ext_b);
    ovf   = raw[DATA_W] ^ raw[DATA_W-1];
    if (ovf && saturate) begin
      sum = raw[DATA_W] ? MIN_V : MAX_V;
    end else begin
      sum = raw[DATA_W-1:0];
    end
  end

endmodule

// File: rtl/fixed_point_adder_pipe.sv
// Two-stage signed Q-format add/sub/accumulate unit with valid/ready on both sides.
module fixed_point_adder_pipe
  import fixed_point_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int FRAC_W   = 4,
  parameter int SATURATE = 1
) (
  input logic                       i_clk,
  input logic                       i_reset_n,
  fixed_point_adder_pipe_if.slave   bus
);

  if (DATA_W < 4 || FRAC_W < 0 || FRAC_W >= DATA_W) begin : g_bad_params
    $error("fixed_point_adder_pipe: need DATA_W >= 4 and 0 <= FRAC_W < DATA_W");
  end

  logic              s1_valid_q, s1_valid_d;
  logic [DATA_W-1:0] s1_a_q, s1_a_d;
  logic [DATA_W-1:0] s1_b_q, s1_b_d;
  logic [1:0]        s1_mode_q, s1_mode_d;
  logic              o_valid_q, o_valid_d;
  logic [DATA_W-1:0] o_data_q, o_data_d;
  logic              o_ovf_q, o_ovf_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic              sticky_q, sticky_d;

  logic              adv1, adv2, load2;
  logic [DATA_W-1:0] add_a, add_b, add_sum;
  logic              add_sub, add_ovf;
  logic [DATA_W-1:0] res_data;
  logic              res_ovf;

  // Stage advance: the output register frees up in the same cycle it is consumed.
  always_comb begin
    adv2  = !o_valid_q || bus.i_ready;
    adv1  = !s1_valid_q || adv2;
    load2 = s1_valid_q && adv2;
  end

  // Operand routing; ACC mode adds the accumulator to A.
  always_comb begin
    add_a   = s1_a_q;
    add_b   = s1_b_q;
    add_sub = 1'b0;
    case (s1_mode_q)
      MODE_SUB: add_sub = 1'b1;
      MODE_ACC: begin
        add_a = acc_q;
        add_b = s1_a_q;
      end
      default: ;
    endcase
  end

  fxp_add_sat #(
    .DATA_W (DATA_W)
  ) u_add_sat (
    .a        (add_a),
    .b        (add_b),
    .sub      (add_sub),
    .saturate (SATURATE != 0),
    .sum      (add_sum),
    .ovf      (add_ovf)
  );

  // Load passes A through untouched and can never overflow.
  always_comb begin
    res_data = add_sum;
    res_ovf  = add_ovf;
    if (s1_mode_q == MODE_LOAD) begin
      res_data = s1_a_q;
      res_ovf  = 1'b0;
    end
  end

  // Next-state for both pipeline stages, accumulator and sticky flag.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_mode_d  = s1_mode_q;
    o_valid_d  = o_valid_q;
    o_data_d   = o_data_q;
    o_ovf_d    = o_ovf_q;
    acc_d      = acc_q;
    sticky_d   = sticky_q;

    if (adv1) begin
      s1_valid_d = bus.i_valid;
      if (bus.i_valid) begin
        s1_a_d    = bus.i_a;
        s1_b_d    = bus.i_b;
        s1_mode_d = bus.i_mode;
      end
    end

    if (adv2) begin
      o_valid_d = s1_valid_q;
    end

    if (load2) begin
      o_data_d = res_data;
      o_ovf_d  = res_ovf;
      if (s1_mode_q == MODE_ACC || s1_mode_q == MODE_LOAD) begin
        acc_d = res_data;
      end
    end

    // A new overflow wins over a clear arriving in the same cycle.
    if (bus.i_clr_sticky) begin
      sticky_d = 1'b0;
    end
    if (load2 && res_ovf) begin
      sticky_d = 1'b1;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_mode_q  <= MODE_ADD;
      o_valid_q  <= 1'b0;
      o_data_q   <= '0;
      o_ovf_q    <= 1'b0;
      acc_q      <= '0;
      sticky_q   <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_mode_q  <= s1_mode_d;
      o_valid_q  <= o_valid_d;
      o_data_q   <= o_data_d;
      o_ovf_q    <= o_ovf_d;
      acc_q      <= acc_d;
      sticky_q   <= sticky_d;
    end
  end

  assign bus.o_ready      = adv1;
  assign bus.o_valid      = o_valid_q;
  assign bus.o_data       = o_data_q;
  assign bus.o_overflow   = o_ovf_q;
  assign bus.o_ovf_sticky = sticky_q;

endmodule

// File: tb/tb_fixed_point_adder_pipe.sv
// Bench for fixed_point_adder_pipe: saturating and wrapping instances share one stimulus.
module tb_fixed_point_adder_pipe;
  import fixed_point_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fixed_point_adder_pipe_if #(.DATA_W(8)) bs ();
  fixed_point_adder_pipe_if #(.DATA_W(8)) bw ();

  assign bw.i_valid      = bs.i_valid;
  assign bw.i_a          = bs.i_a;
  assign bw.i_b          = bs.i_b;
  assign bw.i_mode       = bs.i_mode;
  assign bw.i_ready      = bs.i_ready;
  assign bw.i_clr_sticky = bs.i_clr_sticky;

  fixed_point_adder_pipe #(.DATA_W(8), .FRAC_W(4), .SATURATE(1)) u_dut_sat (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .bus       (bs.slave)
  );

  fixed_point_adder_pipe #(.DATA_W(8), .FRAC_W(4), .SATURATE(0)) u_dut_wrap (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .bus       (bw.slave)
  );

  typedef struct {
    logic [7:0] d;
    bit         ovf;
  } exp_t;

  exp_t q_s[$];
  exp_t q_w[$];
  int   acc_s, acc_w;
  bit   seen_s, seen_w;
  bit   sticky_chk_en;
  int   cyc;
  int   out_cyc[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference arithmetic on plain integers.
  function automatic void ref_op(input int m, input int a, input int b, input int acc,
                                 input bit sat, output int res, output bit ovf);
    int r;
    case (m)
      0: r = a + b;
      1: r = a - b;
      2: r = acc + a;
      default: r = a;
    endcase
    ovf = (r > 127) || (r < -128);
    if (!ovf)     res = r;
    else if (sat) res = (r > 0) ? 127 : -128;
    else          res = (r > 127) ? r - 256 : r + 256;
  endfunction

  // Scoreboard: observe handshakes at the falling edge.
  always @(negedge clk) begin
    int   r;
    bit   o;
    exp_t e;
    cyc++;
    if (!rst_n) begin
      q_s.delete();
      q_w.delete();
      acc_s  = 0;
      acc_w  = 0;
      seen_s = 0;
      seen_w = 0;
    end else begin
      check_eq("o_ready_s", bs.o_ready, (q_s.size() < 2) || bs.i_ready);
      check_eq("o_ready_w", bw.o_ready, (q_w.size() < 2) || bs.i_ready);

      if (bs.o_valid) begin
        if (q_s.size() == 0) begin
          check_eq("spurious_s", q_s.size(), 1);
        end else begin
          check_eq("data_s", bs.o_data, q_s[0].d);
          check_eq("ovf_s", bs.o_overflow, q_s[0].ovf);
          if (sticky_chk_en) check_eq("sticky_s", bs.o_ovf_sticky, seen_s | q_s[0].ovf);
          if (bs.i_ready) begin
            seen_s |= q_s[0].ovf;
            void'(q_s.pop_front());
            out_cyc.push_back(cyc);
          end
        end
      end else if (sticky_chk_en) begin
        check_eq("sticky_idle_s", bs.o_ovf_sticky, seen_s);
      end

      if (bw.o_valid) begin
        if (q_w.size() == 0) begin
          check_eq("spurious_w", q_w.size(), 1);
        end else begin
          check_eq("data_w", bw.o_data, q_w[0].d);
          check_eq("ovf_w", bw.o_overflow, q_w[0].ovf);
          if (sticky_chk_en) check_eq("sticky_w", bw.o_ovf_sticky, seen_w | q_w[0].ovf);
          if (bs.i_ready) begin
            seen_w |= q_w[0].ovf;
            void'(q_w.pop_front());
          end
        end
      end

      if (bs.i_valid && bs.o_ready) begin
        ref_op(int'(bs.i_mode), int'($signed(bs.i_a)), int'($signed(bs.i_b)), acc_s, 1'b1, r, o);
        e.d = 8'(r); e.ovf = o; q_s.push_back(e);
        if (bs.i_mode[1]) acc_s = r;
        ref_op(int'(bs.i_mode), int'($signed(bs.i_a)), int'($signed(bs.i_b)), acc_w, 1'b0, r, o);
        e.d = 8'(r); e.ovf = o; q_w.push_back(e);
        if (bs.i_mode[1]) acc_w = r;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one transaction and hold it until accepted (bounded).
  task automatic send(input logic [1:0] m, input logic [7:0] a, input logic [7:0] b);
    bit got;
    int n;
    bs.i_valid = 1'b1;
    bs.i_mode  = m;
    bs.i_a     = a;
    bs.i_b     = b;
    n = 0;
    do begin
      @(negedge clk);
      got = bs.o_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!got && n < 50);
    if (!got) check_eq("send_timeout", 32'(got), 1);
    bs.i_valid = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout t=%0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    bit took;
    int n;
    rst_n           = 1'b0;
    bs.i_valid      = 1'b0;
    bs.i_a          = '0;
    bs.i_b          = '0;
    bs.i_mode       = MODE_ADD;
    bs.i_ready      = 1'b1;
    bs.i_clr_sticky = 1'b0;
    sticky_chk_en   = 1'b1;
    repeat (3) step();
    check_eq("rst_o_valid_s", bs.o_valid, 0);
    check_eq("rst_o_data_s", bs.o_data, 0);
    check_eq("rst_o_ovf_s", bs.o_overflow, 0);
    check_eq("rst_sticky_s", bs.o_ovf_sticky, 0);
    check_eq("rst_o_valid_w", bw.o_valid, 0);
    rst_n = 1'b1;
    step();

    // 1.5 + 2.5 with two-cycle latency
    send(MODE_ADD, 8'h18, 8'h28);
    check_eq("t1_lat1", bs.o_valid, 0);
    step();
    check_eq("t1_lat2", bs.o_valid, 1);
    check_eq("t1_data", bs.o_data, 8'h40);
    check_eq("t1_ovf", bs.o_overflow, 0);
    step();

    // overflow: saturate vs wrap
    send(MODE_ADD, 8'h70, 8'h20);
    step();
    check_eq("t2_add_s", bs.o_data, 8'h7F);
    check_eq("t2_add_ovf_s", bs.o_overflow, 1);
    check_eq("t2_sticky_s", bs.o_ovf_sticky, 1);
    check_eq("t2_add_w", bw.o_data, 8'h90);
    check_eq("t2_add_ovf_w", bw.o_overflow, 1);
    send(MODE_SUB, 8'h80, 8'h01);
    step();
    check_eq("t2_sub_s", bs.o_data, 8'h80);
    check_eq("t2_sub_ovf_s", bs.o_overflow, 1);
    check_eq("t2_sub_w", bw.o_data, 8'h7F);
    step();

    // load then back-to-back accumulate
    out_cyc.delete();
    send(MODE_LOAD, 8'h10, 8'h00);
    repeat (3) send(MODE_ACC, 8'h10, 8'h00);
    repeat (3) step();
    check_eq("t3_count", out_cyc.size(), 4);
    if (out_cyc.size() == 4) check_eq("t3_span", out_cyc[3] - out_cyc[0], 3);
    send(MODE_ACC, 8'h00, 8'h00);
    step();
    check_eq("t3_acc", bs.o_data, 8'h40);
    step();

    // stream of six with a three-cycle downstream stall
    out_cyc.delete();
    fork
      begin
        for (int i = 0; i < 6; i++) send(MODE_ADD, 8'(i * 7), 8'(i * 3 + 1));
      end
      begin
        repeat (3) step();
        bs.i_ready = 1'b0;
        repeat (3) step();
        bs.i_ready = 1'b1;
      end
    join
    repeat (6) step();
    check_eq("t4_count", out_cyc.size(), 6);
    if (out_cyc.size() == 6) check_eq("t4_span", out_cyc[5] - out_cyc[0], 8);

    // sticky: set beats clear, then clear alone
    sticky_chk_en   = 1'b0;
    bs.i_clr_sticky = 1'b1;
    step();
    bs.i_clr_sticky = 1'b0;
    check_eq("t5_clr0", bs.o_ovf_sticky, 0);
    send(MODE_ADD, 8'h70, 8'h20);
    bs.i_clr_sticky = 1'b1;
    step();
    check_eq("t5_set_wins_s", bs.o_ovf_sticky, 1);
    check_eq("t5_set_wins_w", bw.o_ovf_sticky, 1);
    step();
    check_eq("t5_clr", bs.o_ovf_sticky, 0);
    bs.i_clr_sticky = 1'b0;
    step();

    // reset with two in flight
    send(MODE_ADD, 8'h70, 8'h20);
    send(MODE_ADD, 8'h01, 8'h02);
    check_eq("t6_inflight", bs.o_valid, 1);
    rst_n = 1'b0;
    step();
    check_eq("t6_o_valid", bs.o_valid, 0);
    check_eq("t6_sticky", bs.o_ovf_sticky, 0);
    check_eq("t6_o_data", bs.o_data, 0);
    rst_n         = 1'b1;
    sticky_chk_en = 1'b1;
    send(MODE_ACC, 8'h05, 8'h00);
    step();
    check_eq("t6_acc", bs.o_data, 8'h05);
    check_eq("t6_acc_w", bw.o_data, 8'h05);
    step();

    // randomized traffic with random backpressure
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      took = bs.i_valid && bs.o_ready;
      @(posedge clk);
      #1;
      if (!bs.i_valid || took) begin
        bs.i_valid = ($urandom_range(0, 3) != 0);
        bs.i_mode  = 2'($urandom_range(0, 3));
        bs.i_a     = 8'($urandom);
        bs.i_b     = 8'($urandom);
      end
      bs.i_ready = ($urandom_range(0, 3) != 0);
    end
    bs.i_valid = 1'b0;
    bs.i_ready = 1'b1;
    n = 0;
    while ((q_s.size() != 0 || q_w.size() != 0) && n < 20) begin
      step();
      n++;
    end
    check_eq("drain_s", q_s.size(), 0);
    check_eq("drain_w", q_w.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
